pwm_dac: RTL

PWM digital-to-analog transmitter: accepts NBITS-bit samples over a valid/ready stream and converts each to a PWM duty cycle on `pwm_o`, which drives an external RC low-pass filter. It is the output-direction counterpart of the PWM-ramp ADC in the same analog front-end. Samples are double-buffered and applied only on PWM period boundaries, with optional per-period slew limiting.

---
 rtl/pwm_dac.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pwm_dac.sv
// pwm_dac: PWM transmitter for an external RC low-pass filter.
//
// Each NBITS-bit sample received on the valid/ready stream sets the PWM
// duty cycle. A sample first sits in a one-entry shadow buffer. It is
// promoted to the target duty only on a period boundary, where the active
// duty steps toward the target. The step size is limited by step_i when
// step_i is nonzero.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   enable_i        run the PWM counter; low holds counter at 0, pwm_o low
//   reverse_i       invert PWM polarity while enabled
//   step_i          max change of active duty per period (0 = unlimited)
//   sample_i        new target duty
//   sample_valid_i  sample_i valid
//   sample_ready_o  shadow buffer empty
//   pwm_o           registered PWM output
//   period_o        one-cycle pulse after each period boundary
//   underrun_o      one-cycle pulse after a boundary that found shadow empty
//   settled_o       active duty equals target duty
module pwm_dac #(
  parameter int unsigned          NBITS      = 8,
  parameter logic [NBITS-1:0]     ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             reverse_i,
  input  logic [NBITS-1:0] step_i,
  input  logic [NBITS-1:0] sample_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic             pwm_o,
  output logic             period_o,
  output logic             underrun_o,
  output logic             settled_o
);

  localparam logic [NBITS-1:0] CntMax = '1;

  logic [NBITS-1:0] counter_q;
  logic [NBITS-1:0] shadow_q;
  logic [NBITS-1:0] target_q;
  logic [NBITS-1:0] active_q;
  logic             shadow_full_q;
  logic             pwm_q;
  logic             period_q;
  logic             underrun_q;

  logic             boundary;
  logic             accept;
  logic [NBITS-1:0] new_target;
  logic [NBITS-1:0] slew_diff;
  logic [NBITS-1:0] active_d;

  assign sample_ready_o = !shadow_full_q;
  assign accept         = sample_valid_i && !shadow_full_q;
  assign boundary       = enable_i && (counter_q == CntMax);
  assign new_target     = shadow_full_q ? shadow_q : target_q;

  // Slew limiting: when the distance exceeds step_i, move exactly step_i
  // toward the target. This cannot overshoot or wrap because the distance
  // is strictly larger than the step.
  always_comb begin
    slew_diff = (new_target >= active_q) ? (new_target - active_q)
                                         : (active_q - new_target);
    active_d  = new_target;
    if ((step_i != '0) && (slew_diff > step_i)) begin
      active_d = (new_target > active_q) ? (active_q + step_i)
                                         : (active_q - step_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q <= '0;
    end else if (enable_i) begin
      counter_q <= counter_q + NBITS'(1);
    end else begin
      counter_q <= '0;
    end
  end

  // An accept on the boundary cycle wins over the boundary's clear.
  // The sample is kept for the next boundary, because new_target used the
  // old, empty shadow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      if (boundary) begin
        shadow_full_q <= 1'b0;
      end
      if (accept) begin
        shadow_q      <= sample_i;
        shadow_full_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= ResetValue;
      active_q <= ResetValue;
    end else if (boundary) begin
      target_q <= new_target;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q      <= 1'b0;
      period_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pwm_q      <= enable_i ? ((counter_q < active_q) ^ reverse_i) : 1'b0;
      period_q   <= boundary;
      underrun_q <= boundary && !shadow_full_q;
    end
  end

  assign pwm_o      = pwm_q;
  assign period_o   = period_q;
  assign underrun_o = underrun_q;
  assign settled_o  = (active_q == target_q);

endmodule
